// File: rtl/dec2_flopenr_flopr.sv
// 2-to-4 one-hot decoder alongside two independent WIDTH-bit registers:
// a plain flop and a load-enabled flop, both with synchronous active-high reset.
module dec2_flopenr_flopr #(
  parameter int WIDTH = 8
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic [1:0]       dec_a,
  output logic [3:0]       dec_y,
  input  logic [WIDTH-1:0] r_d,
  output logic [WIDTH-1:0] r_q,
  input  logic             en,
  input  logic [WIDTH-1:0] en_d,
  output logic [WIDTH-1:0] en_q
);

  logic [WIDTH-1:0] r_plain;
  logic [WIDTH-1:0] r_enab;

  // Unknown select bits fall to the default and show up as X rather than 0001.
  always_comb begin
    dec_y = 4'bxxxx;
    case (dec_a)
      2'b00:   dec_y = 4'b0001;
      2'b01:   dec_y = 4'b0010;
      2'b10:   dec_y = 4'b0100;
      2'b11:   dec_y = 4'b1000;
      default: dec_y = 4'bxxxx;
    endcase
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_plain <= '0;
    end else begin
      r_plain <= r_d;
    end
  end

  // Reset wins over a simultaneous load; en=0 holds the previous contents.
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_enab <= '0;
    end else if (en) begin
      r_enab <= en_d;
    end
  end

  assign r_q  = r_plain;
  assign en_q = r_enab;

endmodule

// File: tb/tb_dec2_flopenr_flopr.sv
// Scoreboarded bench for dec2_flopenr_flopr at WIDTH 8, 27 and 1.
module tb_dec2_flopenr_flopr;

  typedef struct packed {
    logic [3:0]  dec;
    logic [7:0]  r8;
    logic [7:0]  e8;
    logic [26:0] r27;
    logic [26:0] e27;
    logic        r1;
    logic        e1;
  } exp_t;

  // clock / reset block
  logic ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  // DUT-facing signals (changed only at the falling edge)
  logic        reset;
  logic [1:0]  dec_a;
  logic [7:0]  r_d8, en_d8, r_q8, en_q8;
  logic        en8;
  logic [26:0] r_d27, en_d27, r_q27, en_q27;
  logic        en27;
  logic        r_d1, en_d1, r_q1, en_q1, en1;
  logic [3:0]  dec_y8, dec_y27, dec_y1;

  // stimulus staging, copied onto the DUT inputs by issue()
  logic        s_rst;
  logic [1:0]  s_da;
  logic [7:0]  s_rd8, s_ed8;
  logic        s_en8;
  logic [26:0] s_rd27, s_ed27;
  logic        s_en27;
  logic        s_rd1, s_ed1, s_en1;

  // reference model state
  logic [7:0]  m_r8, m_e8;
  logic [26:0] m_r27, m_e27;
  logic        m_r1, m_e1;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  dec2_flopenr_flopr #(.WIDTH(8)) u_w8 (
    .ph1(ph1), .reset(reset), .dec_a(dec_a), .dec_y(dec_y8),
    .r_d(r_d8), .r_q(r_q8), .en(en8), .en_d(en_d8), .en_q(en_q8)
  );

  dec2_flopenr_flopr #(.WIDTH(27)) u_w27 (
    .ph1(ph1), .reset(reset), .dec_a(dec_a), .dec_y(dec_y27),
    .r_d(r_d27), .r_q(r_q27), .en(en27), .en_d(en_d27), .en_q(en_q27)
  );

  dec2_flopenr_flopr #(.WIDTH(1)) u_w1 (
    .ph1(ph1), .reset(reset), .dec_a(dec_a), .dec_y(dec_y1),
    .r_d(r_d1), .r_q(r_q1), .en(en1), .en_d(en_d1), .en_q(en_q1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus; optional reset glitch between edges
  task automatic issue(input bit glitch);
    exp_t e;
    @(negedge ph1);
    reset  = s_rst;   dec_a  = s_da;
    r_d8   = s_rd8;   en8    = s_en8;  en_d8  = s_ed8;
    r_d27  = s_rd27;  en27   = s_en27; en_d27 = s_ed27;
    r_d1   = s_rd1;   en1    = s_en1;  en_d1  = s_ed1;
    if (s_rst) begin
      m_r8 = '0; m_e8 = '0; m_r27 = '0; m_e27 = '0; m_r1 = 1'b0; m_e1 = 1'b0;
    end else begin
      m_r8 = s_rd8; m_r27 = s_rd27; m_r1 = s_rd1;
      if (s_en8)  m_e8  = s_ed8;
      if (s_en27) m_e27 = s_ed27;
      if (s_en1)  m_e1  = s_ed1;
    end
    e.dec = 4'(1 << s_da);
    e.r8 = m_r8;   e.e8 = m_e8;
    e.r27 = m_r27; e.e27 = m_e27;
    e.r1 = m_r1;   e.e1 = m_e1;
    exp_q.push_back(e);
    if (glitch && !s_rst) begin
      #2 reset = 1'b1;
      #2 reset = 1'b0;
    end
  endtask

  // monitor: every rising edge the DUT presents new register contents
  always @(posedge ph1) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dec_y_w8",  32'(dec_y8),  32'(e.dec));
      chk("dec_y_w27", 32'(dec_y27), 32'(e.dec));
      chk("dec_y_w1",  32'(dec_y1),  32'(e.dec));
      chk("r_q_w8",    32'(r_q8),    32'(e.r8));
      chk("en_q_w8",   32'(en_q8),   32'(e.e8));
      chk("r_q_w27",   32'(r_q27),   32'(e.r27));
      chk("en_q_w27",  32'(en_q27),  32'(e.e27));
      chk("r_q_w1",    32'(r_q1),    32'(e.r1));
      chk("en_q_w1",   32'(en_q1),   32'(e.e1));
    end
  end

  task automatic set_all(input logic rst, input logic [1:0] da,
                         input logic [7:0] rd8, input logic en8_i, input logic [7:0] ed8,
                         input logic [26:0] rd27, input logic en27_i, input logic [26:0] ed27,
                         input logic rd1, input logic en1_i, input logic ed1);
    s_rst = rst; s_da = da;
    s_rd8 = rd8;   s_en8 = en8_i;   s_ed8 = ed8;
    s_rd27 = rd27; s_en27 = en27_i; s_ed27 = ed27;
    s_rd1 = rd1;   s_en1 = en1_i;   s_ed1 = ed1;
  endtask

  initial begin
    reset = 1'b1; dec_a = '0;
    r_d8 = '0; en8 = 1'b0; en_d8 = '0;
    r_d27 = '0; en27 = 1'b0; en_d27 = '0;
    r_d1 = 1'b0; en1 = 1'b0; en_d1 = 1'b0;

    // reset held two edges, decoder swept while in reset
    set_all(1, 2'd0, 8'h00, 0, 8'h00, 27'h0, 0, 27'h0, 0, 0, 0); issue(0);
    set_all(1, 2'd1, 8'h55, 1, 8'h77, 27'h7FFFFFF, 1, 27'h7FFFFFF, 1, 1, 1); issue(0);
    // first loads
    set_all(0, 2'd2, 8'hA5, 1, 8'h3C, 27'h7FFFFFF, 1, 27'h5A5A5A5, 1, 1, 1); issue(0);
    // enable low for three edges with new data offered
    for (int i = 0; i < 3; i++) begin
      set_all(0, 2'(i), 8'h5A, 0, 8'hFF, 27'h1234567, 0, 27'h7FFFFFF, 0, 0, 0); issue(0);
    end
    set_all(0, 2'd3, 8'h5A, 1, 8'hFF, 27'h1234567, 1, 27'h7FFFFFF, 0, 1, 0); issue(0);
    // reset and enable on the same edge
    set_all(1, 2'd3, 8'h55, 1, 8'h77, 27'h7FFFFFF, 1, 27'h7FFFFFF, 1, 1, 1); issue(0);
    // reset pulse between edges must not clear anything
    set_all(0, 2'd1, 8'h12, 1, 8'h99, 27'h0ABCDEF, 1, 27'h7654321, 1, 1, 1); issue(0);
    set_all(0, 2'd2, 8'h12, 0, 8'h00, 27'h0ABCDEF, 0, 27'h0000000, 1, 0, 0); issue(1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_all(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
              8'($urandom), 1'($urandom), 8'($urandom),
              27'($urandom), 1'($urandom), 27'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
      issue($urandom_range(0, 7) == 0);
    end

    // bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge ph1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
